// File: rtl/call_queue_pkg.sv
// Shared elevator definitions for the call queue: floor count, direction
// encodings, button indexing and the pending-request population count.
package call_queue_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int NUM_BTNS   = 10;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic {
        FLT_ARMED,
        FLT_HELD
    } flt_state_t;

    function automatic logic [3:0] count_pending(input logic [NUM_BTNS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/call_queue_btn_filter.sv
// Debounce for one active-low button: emits a one-cycle accept pulse after
// DEB_CYCLES low samples, then waits for DEB_CYCLES high samples before re-arming.
//
// state     | meaning
// FLT_ARMED | counting consecutive low samples toward a press
// FLT_HELD  | press accepted; counting consecutive high samples toward release
module btn_filter
    import call_queue_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic raw_n,
    output logic accept
);

    localparam logic [3:0] TC = 4'(DEB_CYCLES - 1);

    flt_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept_q, accept_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= FLT_ARMED;
            cnt_q    <= 4'd0;
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        case (state_q)
            FLT_ARMED: begin
                if (raw_n) begin
                    cnt_d = 4'd0;
                end else if (cnt_q == TC) begin
                    accept_d = 1'b1;
                    state_d  = FLT_HELD;
                    cnt_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FLT_HELD: begin
                if (!raw_n) begin
                    cnt_d = 4'd0;
                end else if (cnt_q == TC) begin
                    state_d = FLT_ARMED;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = FLT_ARMED;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign accept = accept_q;

endmodule

// File: rtl/call_queue.sv
// Elevator call queue: debounces cab and hall buttons, latches pending requests,
// clears them when the door opens at the matching floor, and summarises them.
module call_queue
    import call_queue_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [4:1] bn0,
    input  logic [3:1] upn0,
    input  logic [4:2] downn0,
    input  logic [2:0] floor,
    input  logic [1:0] updown,
    input  logic       open,
    output logic [4:1] bn,
    output logic [3:1] upn,
    output logic [4:2] downn,
    output logic       req_above,
    output logic       req_below,
    output logic       req_here,
    output logic [3:0] pend_cnt
);

    // Button vector layout: [3:0] cab 1..4, [6:4] hall-up 1..3, [9:7] hall-down 2..4
    logic [NUM_BTNS-1:0] raw_n;
    logic [NUM_BTNS-1:0] acc;
    logic [NUM_BTNS-1:0] clr_vec;
    logic [NUM_BTNS-1:0] pend_q;
    logic [NUM_BTNS-1:0] pend_d;
    logic [NUM_FLOORS:1] floor_pend;
    logic                floor_ok;
    logic                dir_up;
    logic                dir_down;

    assign raw_n = {downn0, upn0, bn0};

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_flt
        btn_filter #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_flt (
            .clk   (clk),
            .clr   (clr),
            .raw_n (raw_n[gi]),
            .accept(acc[gi])
        );
    end

    assign floor_ok = (floor >= 3'd1) && (floor <= 3'(NUM_FLOORS));
    assign dir_up   = (updown == DIR_UP);
    assign dir_down = (updown == DIR_DOWN);

    // Code 11 decodes as neither up nor down, so it clears both hall directions.
    always_comb begin
        clr_vec = '0;
        if (open && floor_ok) begin
            for (int f = 1; f <= NUM_FLOORS; f++) begin
                if (floor == 3'(f)) begin
                    clr_vec[f-1] = 1'b1;
                    if (f <= 3 && !dir_down) clr_vec[4+f-1] = 1'b1;
                    if (f >= 2 && !dir_up)   clr_vec[7+f-2] = 1'b1;
                end
            end
        end
    end

    assign pend_d = (pend_q | acc) & ~clr_vec;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    always_comb begin
        floor_pend[1] = pend_q[0] | pend_q[4];
        floor_pend[2] = pend_q[1] | pend_q[5] | pend_q[7];
        floor_pend[3] = pend_q[2] | pend_q[6] | pend_q[8];
        floor_pend[4] = pend_q[3] | pend_q[9];
    end

    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        req_here  = 1'b0;
        if (floor_ok) begin
            for (int f = 1; f <= NUM_FLOORS; f++) begin
                if (3'(f) > floor)  req_above = req_above | floor_pend[f];
                if (3'(f) < floor)  req_below = req_below | floor_pend[f];
                if (3'(f) == floor) req_here  = req_here  | floor_pend[f];
            end
        end
    end

    assign bn       = pend_q[3:0];
    assign upn      = pend_q[6:4];
    assign downn    = pend_q[9:7];
    assign pend_cnt = count_pending(pend_q);

endmodule

// File: tb/tb_call_queue.sv
// Directed bench for call_queue: debounce latency, bounce rejection,
// direction-aware clearing, clear-over-set priority, invalid floors and reset.
module tb_call_queue;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:1] bn0;
    logic [3:1] upn0;
    logic [4:2] downn0;
    logic [2:0] floor;
    logic [1:0] updown;
    logic       open;
    logic [4:1] bn;
    logic [3:1] upn;
    logic [4:2] downn;
    logic       req_above;
    logic       req_below;
    logic       req_here;
    logic [3:0] pend_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    call_queue #(.DEB_CYCLES(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .bn0      (bn0),
        .upn0     (upn0),
        .downn0   (downn0),
        .floor    (floor),
        .updown   (updown),
        .open     (open),
        .bn       (bn),
        .upn      (upn),
        .downn    (downn),
        .req_above(req_above),
        .req_below(req_below),
        .req_here (req_here),
        .pend_cnt (pend_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clr    = 1'b1;
        bn0    = 4'hF;
        upn0   = 3'h7;
        downn0 = 3'h7;
        floor  = 3'd1;
        updown = 2'b00;
        open   = 1'b0;
        tick(2);
        chk("rst_bn", 32'(bn), 32'h0);
        chk("rst_upn", 32'(upn), 32'h0);
        chk("rst_downn", 32'(downn), 32'h0);
        chk("rst_cnt", 32'(pend_cnt), 32'h0);
        chk("rst_req", 32'({req_above, req_below, req_here}), 32'h0);
        clr = 1'b0;

        // cab 3 press: lamp appears on the fifth edge
        bn0[3] = 1'b0;
        tick(4);
        chk("026_bn_early", 32'(bn), 32'h0);
        tick(1);
        chk("026_bn", 32'(bn), 32'b0100);
        chk("026_cnt", 32'(pend_cnt), 32'd1);
        chk("026_req", 32'({req_above, req_below, req_here}), 32'b100);
        bn0[3] = 1'b1;

        // bouncing hall-up 2 never reaches four consecutive lows
        repeat (4) begin
            upn0[2] = 1'b0;
            tick(3);
            upn0[2] = 1'b1;
            tick(1);
        end
        chk("027_upn", 32'(upn), 32'h0);
        chk("027_cnt", 32'(pend_cnt), 32'd1);

        floor = 3'd3;
        open  = 1'b1;
        tick(1);
        chk("clr3_bn", 32'(bn), 32'h0);
        chk("clr3_cnt", 32'(pend_cnt), 32'd0);
        open  = 1'b0;
        floor = 3'd1;

        // three requests at floor 2, then clear while moving up
        bn0[2] = 1'b0; upn0[2] = 1'b0; downn0[2] = 1'b0;
        tick(5);
        bn0[2] = 1'b1; upn0[2] = 1'b1; downn0[2] = 1'b1;
        chk("028_set_bn", 32'(bn), 32'b0010);
        chk("028_set_upn", 32'(upn), 32'b010);
        chk("028_set_downn", 32'(downn), 32'b001);
        chk("028_set_cnt", 32'(pend_cnt), 32'd3);
        chk("028_set_above", 32'(req_above), 32'd1);
        floor  = 3'd2;
        updown = 2'b01;
        open   = 1'b1;
        tick(1);
        chk("028_upn", 32'(upn), 32'h0);
        chk("028_bn", 32'(bn), 32'h0);
        chk("028_downn", 32'(downn), 32'b001);
        chk("028_cnt", 32'(pend_cnt), 32'd1);
        chk("028_here", 32'(req_here), 32'd1);
        open   = 1'b0;
        updown = 2'b00;

        // cab 4 held across an open door: no re-set until release and re-press
        floor  = 3'd4;
        open   = 1'b1;
        bn0[4] = 1'b0;
        tick(5);
        chk("029_clear_wins", 32'(bn), 32'h0);
        open = 1'b0;
        tick(4);
        chk("029_held", 32'(bn), 32'h0);
        bn0[4] = 1'b1;
        tick(4);
        bn0[4] = 1'b0;
        tick(4);
        chk("029_repress_early", 32'(bn), 32'h0);
        tick(1);
        chk("029_repress", 32'(bn), 32'b1000);
        chk("029_req", 32'({req_above, req_below, req_here}), 32'b011);
        chk("029_cnt", 32'(pend_cnt), 32'd2);
        bn0[4] = 1'b1;

        // hall-down 3 accepted while the door is open there
        floor     = 3'd3;
        open      = 1'b1;
        downn0[3] = 1'b0;
        tick(5);
        chk("030_clear_wins", 32'(downn), 32'b001);
        downn0[3] = 1'b1;
        open      = 1'b0;
        tick(4);
        downn0[3] = 1'b0;
        tick(5);
        chk("030_set", 32'(downn), 32'b011);
        downn0[3] = 1'b1;
        updown    = 2'b01;
        open      = 1'b1;
        tick(1);
        chk("030_up_keeps", 32'(downn), 32'b011);
        updown = 2'b11;
        tick(1);
        chk("030_dir11_clears", 32'(downn), 32'b001);
        open   = 1'b0;
        updown = 2'b00;

        // invalid floor: no clears and no req_* even with the door open
        floor   = 3'd6;
        open    = 1'b1;
        bn0[1]  = 1'b0; upn0[1] = 1'b0; upn0[3] = 1'b0;
        tick(5);
        bn0[1]  = 1'b1; upn0[1] = 1'b1; upn0[3] = 1'b1;
        chk("031_cnt", 32'(pend_cnt), 32'd5);
        chk("031_bn", 32'(bn), 32'b1001);
        chk("031_upn", 32'(upn), 32'b101);
        chk("031_req_f6", 32'({req_above, req_below, req_here}), 32'b000);
        floor = 3'd0;
        tick(1);
        chk("031_req_f0", 32'({req_above, req_below, req_here}), 32'b000);
        chk("031_cnt_f0", 32'(pend_cnt), 32'd5);
        open  = 1'b0;
        floor = 3'd2;
        #1;
        chk("031_req_f2", 32'({req_above, req_below, req_here}), 32'b111);
        clr = 1'b1;
        #1;
        chk("031_clr_cnt", 32'(pend_cnt), 32'd0);
        chk("031_clr_lamps", 32'({bn, upn, downn}), 32'h0);
        chk("031_clr_req", 32'({req_above, req_below, req_here}), 32'b000);
        tick(1);
        clr = 1'b0;

        // press in progress is discarded by clr
        bn0[1] = 1'b0;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(4);
        chk("023_early", 32'(bn), 32'h0);
        tick(1);
        chk("023_bn", 32'(bn), 32'b0001);
        chk("023_cnt", 32'(pend_cnt), 32'd1);
        bn0[1] = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/call_queue.md
CALL_QUEUE -- requirements
Module: call_queue

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, meaning consecutive low samples needed to accept a press (range 2..15).
REQ-002 SHALL have port clk, input, 1, single system clock (190 Hz domain).
REQ-003 SHALL have port clr, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port bn0, input, [4:1], raw cab buttons, active-low.
REQ-005 SHALL have port upn0, input, [3:1], raw hall-up buttons, active-low.
REQ-006 SHALL have port downn0, input, [4:2], raw hall-down buttons, active-low.
REQ-007 SHALL have port floor, input, [2:0], current car floor; 1..4 valid.
REQ-008 SHALL have port updown, input, [1:0], car direction; 00 idle, 01 up, 10 down, 11 treated as idle.
REQ-009 SHALL have port open, input, 1, door open, active-high.
REQ-010 SHALL have ports bn [4:1], upn [3:1] and downn [4:2], outputs, pending-request lamps, active-high.
REQ-011 SHALL have ports req_above, req_below and req_here, outputs, 1 bit each, any pending request above, below or at floor.
REQ-012 SHALL have port pend_cnt, output, [3:0], number of pending requests (0..10).

Function
REQ-013 SHALL filter each of the 10 raw inputs independently: a press is accepted when the input has been sampled low for DEB_CYCLES consecutive clk edges.
REQ-014 SHALL treat any high sample as a bounce; the stability counter resets to 0.
REQ-015 SHALL record a filtered press once, on its accept edge; holding the button SHALL NOT re-set a cleared request until release (DEB_CYCLES high samples) and a fresh press.
REQ-016 SHALL set the pending bit one cycle after the accept edge; total latency from stable low to lamp high is DEB_CYCLES+1 cycles.
REQ-017 SHALL clear pending bits while open=1 and floor=f (1..4): bn[f] always; upn[f] if updown is up or idle; downn[f] if updown is down or idle.
REQ-018 SHALL give clear priority over set when both hit the same bit in the same cycle.
REQ-019 SHALL perform no clears when floor is 0 or 5..7; req_above, req_below and req_here SHALL then be 0.
REQ-020 SHALL derive req_above, req_below, req_here and pend_cnt combinationally from the pending registers and floor, with no extra latency.
REQ-021 SHALL hold pending bits indefinitely while not cleared; setting an already-set bit has no effect.

Reset
REQ-022 SHALL, while clr=1, drive all lamps, req_* and pend_cnt to 0 and zero every filter counter and accept flag.
REQ-023 SHALL discard a press in progress when clr asserts mid-filter; after release of clr, a held button needs a full DEB_CYCLES before it is accepted.

Structure
REQ-024 SHALL take NUM_FLOORS=4 and the updown encodings (DIR_IDLE, DIR_UP, DIR_DOWN) from the shared elevator package.
REQ-025 SHALL implement filtering in one sub-module, btn_filter (counter, accept-edge pulse, release tracking), instantiated 10 times.

Verification
REQ-026 Verify: bn0[3] low for 4 cycles -> bn[3]=1 at cycle 5; pend_cnt=1; with floor=1, req_above=1.
REQ-027 Verify: upn0[2] toggling low 3 cycles then high 1, repeated -> upn[2] stays 0.
REQ-028 Verify: upn[2], downn[2] and bn[2] pending; floor=2, updown=01, open=1 -> next cycle upn[2]=0, bn[2]=0, downn[2]=1, pend_cnt=1.
REQ-029 Verify: bn0[4] held low across a clear (floor=4, open=1, idle) -> bn[4] stays 0; release, then 4 new low cycles -> bn[4]=1.
REQ-030 Verify: accept edge for downn0[3] coincides with floor=3, updown=00, open=1 -> downn[3]=0 (clear wins).
REQ-031 Verify: clr pulsed with 5 requests pending and floor=6 -> all outputs 0; floor=6 with pending bits -> req_* = 0.
